// File: rtl/multichannel_moving_sum.sv
// multichannel_moving_sum: time-multiplexed per-channel moving sum over a shared circular-buffer RAM
module multichannel_moving_sum #(
  parameter int MAX_LENGTH = 1024,
  parameter int DATA_BITS = 32,
  parameter int CHANNELS = 4,
  localparam int ADDR_WIDTH = $clog2(MAX_LENGTH),
  localparam int CH_BITS = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int SUM_BITS = DATA_BITS + ADDR_WIDTH + 1
) (
  input  logic                       i_clock,
  input  logic                       i_reset_n,
  input  logic                       i_clear,
  input  logic [ADDR_WIDTH:0]        i_length,
  input  logic                       i_in_valid,
  input  logic [CH_BITS-1:0]         i_in_channel,
  input  logic [DATA_BITS-1:0]       i_data_in,
  output logic                       o_ready,
  output logic                       o_out_valid,
  output logic [CH_BITS-1:0]         o_out_channel,
  output logic signed [SUM_BITS-1:0] o_sum_out
);
  localparam int RAM_AW = CH_BITS + ADDR_WIDTH;
  localparam int DEPTH = CHANNELS * MAX_LENGTH;
  localparam logic [RAM_AW:0] SWEEP_FULL = (RAM_AW + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] L_MAX = (ADDR_WIDTH + 1)'(MAX_LENGTH);
  localparam logic [CH_BITS:0] CH_LIM = (CH_BITS + 1)'(CHANNELS);
  typedef enum logic {S_CLEAR, S_RUN} state_t;
  state_t                     r_state;
  logic [RAM_AW:0]            r_sweep_cnt;
  logic                       r_already_clear;
  logic [ADDR_WIDTH:0]        r_len;
  logic [ADDR_WIDTH-1:0]      r_ptr [CHANNELS];
  logic signed [SUM_BITS-1:0] r_sum [CHANNELS];
  logic [DATA_BITS-1:0]       r_ram [DEPTH];
  logic [DATA_BITS-1:0]       r_old;
  logic [DATA_BITS-1:0]       r_s1_new;
  logic                       r_s1_valid;
  logic [CH_BITS-1:0]         r_s1_ch;
  logic                       r_out_valid;
  logic [CH_BITS-1:0]         r_out_ch;
  logic signed [SUM_BITS-1:0] r_sum_out;
  logic                       w_accept;
  logic                       w_sweep_we;
  logic [ADDR_WIDTH-1:0]      w_ptr;
  logic [ADDR_WIDTH-1:0]      w_ptr_next;
  logic [RAM_AW-1:0]          w_addr;
  logic [ADDR_WIDTH:0]        w_len_clamped;
  logic signed [SUM_BITS-1:0] w_sum_next;
  // Accept/sweep decode, RAM address mux, pointer wrap, window clamp and sum update
  always_comb begin
    w_accept = (r_state == S_RUN) && i_in_valid && !i_clear && ({1'b0, i_in_channel} < CH_LIM);
    w_sweep_we = (r_state == S_CLEAR) && (r_sweep_cnt != '0);
    w_ptr = r_ptr[i_in_channel];
    w_ptr_next = ({1'b0, w_ptr} == r_len - 1'b1) ? '0 : w_ptr + 1'b1;
    w_addr = w_sweep_we ? RAM_AW'(r_sweep_cnt - 1'b1) : {i_in_channel, w_ptr};
    w_len_clamped = (i_length == '0) ? (ADDR_WIDTH + 1)'(1) : (i_length > L_MAX) ? L_MAX : i_length;
    w_sum_next = r_sum[r_s1_ch] + SUM_BITS'($signed(r_s1_new)) - SUM_BITS'($signed(r_old));
  end
  // Delay-line RAM: read-before-write, zeroed by the sweep rather than by reset
  always_ff @(posedge i_clock) begin
    if (w_sweep_we || w_accept) r_ram[w_addr] <= w_sweep_we ? '0 : i_data_in;
    r_old <= r_ram[w_addr];
  end
  // Control FSM plus the two-stage accept/accumulate pipeline
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= S_CLEAR;
      r_sweep_cnt <= SWEEP_FULL;
      r_already_clear <= 1'b0;
      r_len <= (ADDR_WIDTH + 1)'(1);
      r_s1_valid <= 1'b0;
      r_s1_ch <= '0;
      r_s1_new <= '0;
      r_out_valid <= 1'b0;
      r_out_ch <= '0;
      r_sum_out <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        r_ptr[c] <= '0;
        r_sum[c] <= '0;
      end
    end else if (i_clear) begin
      r_state <= S_CLEAR;
      r_sweep_cnt <= r_already_clear ? '0 : SWEEP_FULL;
      r_s1_valid <= 1'b0;
      r_out_valid <= 1'b0;
      r_sum_out <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        r_ptr[c] <= '0;
        r_sum[c] <= '0;
      end
    end else begin
      if (r_state == S_CLEAR) begin
        r_sweep_cnt <= w_sweep_we ? r_sweep_cnt - 1'b1 : r_sweep_cnt;
        if (r_sweep_cnt < (RAM_AW + 1)'(2)) begin
          r_state <= S_RUN;
          r_already_clear <= 1'b1;
          r_len <= w_len_clamped;
        end
      end
      r_s1_valid <= w_accept;
      r_s1_ch <= i_in_channel;
      r_s1_new <= i_data_in;
      if (w_accept) begin
        r_ptr[i_in_channel] <= w_ptr_next;
        r_already_clear <= 1'b0;
      end
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_sum[r_s1_ch] <= w_sum_next;
        r_sum_out <= w_sum_next;
        r_out_ch <= r_s1_ch;
      end
    end
  end
  assign o_ready = (r_state == S_RUN);
  assign o_out_valid = r_out_valid;
  assign o_out_channel = r_out_ch;
  assign o_sum_out = r_sum_out;
endmodule
